ctrl_var_arbiter: RTL

Shared-access controller for the debug control-variable register file. It arbitrates read/write/add/subtract commands from up to NUM_REQ requesters (for example the front-panel button editor, a host debug port, or game logic) and serialises them onto a single read-modify-write path. It is the sole writer of `control_vars`, which the rest of the design consumes as static 16-bit tuning values.

---
 rtl/ctrl_var_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ctrl_var_arbiter.sv
// ctrl_var_arbiter
//   Serialises read/write/add/sub commands from NUM_REQ requesters onto a
//   single read-modify-write path into the control-variable file. This block
//   is the only writer of the control variables.
//
// Ports
//   clk_i           system clock
//   reset_n_i       synchronous active-low reset
//   req_i           per-requester request level, held until ack
//   op_i            per-requester command (0 WRITE, 1 ADD, 2 SUB, 3 READ), 2 bits each
//   idx_i           per-requester variable index, IDX_W bits each
//   wdata_i         per-requester operand, 16 bits each
//   ack_o           one-cycle completion pulse to the granted requester
//   rdata_o         variable value before the command (valid in ack cycle)
//   err_o           index out of range (valid in ack cycle)
//   busy_o          high whenever the FSM is not idle
//   control_vars_o  registered variable file, 16 bits per variable
//
// state  | meaning
// IDLE   | waiting for a request; round-robin pick and latch of the command
// EXEC   | read-modify-write of the latched variable, register ack/rdata/err
// ACK    | ack/rdata/err visible for one cycle
module ctrl_var_arbiter #(
    parameter int NUM_CTRL_VARS = 16,
    parameter int NUM_REQ       = 4,
    localparam int IDX_W = (NUM_CTRL_VARS > 1) ? $clog2(NUM_CTRL_VARS) : 1
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ*2-1:0]        op_i,
    input  logic [NUM_REQ*IDX_W-1:0]    idx_i,
    input  logic [NUM_REQ*16-1:0]       wdata_i,
    output logic [NUM_REQ-1:0]          ack_o,
    output logic [15:0]                 rdata_o,
    output logic                        err_o,
    output logic                        busy_o,
    output logic [NUM_CTRL_VARS*16-1:0] control_vars_o
);

    localparam int GNT_W = $clog2(NUM_REQ);
    localparam logic [GNT_W-1:0] LAST_REQ = GNT_W'(NUM_REQ - 1);
    // One extra bit so the range compare is never trivially constant.
    localparam logic [IDX_W:0] NUM_V = (IDX_W + 1)'(NUM_CTRL_VARS);

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_ADD   = 2'd1;
    localparam logic [1:0] OP_SUB   = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ACK} state_t;

    state_t             state_q, state_d;
    logic [GNT_W-1:0]   grant_q, grant_d;
    logic [GNT_W-1:0]   last_grant_q, last_grant_d;
    logic [1:0]         op_q, op_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [15:0]        wdata_q, wdata_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [15:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic [15:0]        vars_q [NUM_CTRL_VARS];
    logic [15:0]        vars_d [NUM_CTRL_VARS];

    logic               found;
    logic [GNT_W-1:0]   winner;
    logic [GNT_W-1:0]   cand;
    logic               in_range;
    logic [15:0]        old_val;

    function automatic logic [15:0] reset_val(input int i);
        case (i)
            0:       return 16'd50;
            1:       return 16'd10;
            2:       return 16'd16;
            3:       return 16'h0100;
            default: return 16'h0000;
        endcase
    endfunction

    // Round-robin: search starts one past the last grant and wraps.
    always_comb begin
        found  = 1'b0;
        winner = last_grant_q;
        cand   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = GNT_W'((int'(last_grant_q) + i) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign in_range = ({1'b0, idx_q} < NUM_V);
    assign old_val  = in_range ? vars_q[idx_q] : 16'h0000;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        ack_d        = '0;
        rdata_d      = rdata_q;
        err_d        = err_q;
        for (int i = 0; i < NUM_CTRL_VARS; i++) vars_d[i] = vars_q[i];

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d = winner;
                    op_d    = op_i[winner*2 +: 2];
                    idx_d   = idx_i[winner*IDX_W +: IDX_W];
                    wdata_d = wdata_i[winner*16 +: 16];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                rdata_d        = old_val;
                err_d          = !in_range;
                ack_d[grant_q] = 1'b1;
                last_grant_d   = grant_q;
                state_d        = S_ACK;
                if (in_range) begin
                    case (op_q)
                        OP_WRITE: vars_d[idx_q] = wdata_q;
                        OP_ADD:   vars_d[idx_q] = old_val + wdata_q;
                        OP_SUB:   vars_d[idx_q] = old_val - wdata_q;
                        default:  ;
                    endcase
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_REQ;
            op_q         <= '0;
            idx_q        <= '0;
            wdata_q      <= '0;
            ack_q        <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            for (int i = 0; i < NUM_CTRL_VARS; i++) vars_q[i] <= reset_val(i);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            ack_q        <= ack_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            for (int i = 0; i < NUM_CTRL_VARS; i++) vars_q[i] <= vars_d[i];
        end
    end

    assign ack_o   = ack_q;
    assign rdata_o = rdata_q;
    assign err_o   = err_q;
    assign busy_o  = (state_q != S_IDLE);

    for (genvar g = 0; g < NUM_CTRL_VARS; g++) begin : g_cv
        assign control_vars_o[g*16 +: 16] = vars_q[g];
    end

endmodule
